ped_panel: RTL
==============

PED_PANEL -- requirements
Module: ped_panel

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 5, clock cycles per second.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 3, consecutive stable samples needed to accept a button level.
REQ-003 SHALL have parameter WALK_SECS, default 4, solid-WALK duration in seconds.
REQ-004 SHALL have parameter FLASH_SECS, default 2, flashing DON'T-WALK duration in seconds.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports btn_NS, btn_EW  input  1 each  raw asynchronous pedestrian buttons.
REQ-008 SHALL have ports NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green  input  1 each  controller lamp states.
REQ-009 SHALL have ports ped_wait_NS, ped_wait_EW  input  1 each  controller wait acknowledgements.
REQ-010 SHALL have ports ped_NS, ped_EW  output  1 each  latched request levels to the controller.
REQ-011 SHALL have ports walk_NS, dont_walk_NS, walk_EW, dont_walk_EW  output  1 each  pedestrian signal heads.
REQ-012 SHALL have ports wait_lamp_NS, wait_lamp_EW  output  1 each  "request registered" indicators.
REQ-013 SHALL have port secs_left  output  4  crossing countdown in seconds, 0 when idle.

Function
REQ-014 Each button SHALL pass a 2-flop synchroniser, then a debouncer that updates its output only after DEBOUNCE_CYCLES identical consecutive synchronised samples.
REQ-015 A debounced rising edge on btn_X SHALL set req_X the following cycle; ped_X = req_X (registered).
REQ-016 req_X SHALL stay set until the X crossing starts; repeated presses while set SHALL have no effect.
REQ-017 A press edge arriving in the same cycle the X crossing starts, or during the X crossing, SHALL be ignored.
REQ-018 wait_lamp_X SHALL equal req_X OR ped_wait_X.
REQ-019 FSM states: IDLE, WALK_NS, FLASH_NS, WALK_EW, FLASH_EW.
REQ-020 IDLE -> WALK_NS when req_NS and NS_green and EW_red; IDLE -> WALK_EW when req_EW and EW_green and NS_red; if both qualify, NS wins.
REQ-021 On crossing entry: secs_left loads WALK_SECS+FLASH_SECS, prescaler clears, req_X clears.
REQ-022 Prescaler counts 0..CLK_FREQ-1; on wrap secs_left decrements.
REQ-023 WALK_X -> FLASH_X when secs_left reaches FLASH_SECS; FLASH_X -> IDLE when secs_left reaches 0.
REQ-024 In WALK_X: walk_X=1, dont_walk_X=0; in FLASH_X: walk_X=0, dont_walk_X toggles every max(CLK_FREQ/2,1) cycles, starting at 1.
REQ-025 Outside its crossing, walk_X=0 and dont_walk_X=1 solid.
REQ-026 Abort: in WALK_X/FLASH_X, if X_green deasserts, SHALL go to IDLE next cycle, secs_left=0, request not re-latched.
REQ-027 Defaults: full crossing = (WALK_SECS+FLASH_SECS)*CLK_FREQ = 30 cycles.
REQ-028 secs_left SHALL saturate at 0; WALK_SECS+FLASH_SECS > 15 is illegal (elaboration assertion).

Reset
REQ-029 On rst: state IDLE, req_NS=req_EW=0, ped_NS=ped_EW=0, walk_*=0, dont_walk_*=1, wait_lamp_* follows ped_wait_*, secs_left=0, prescaler=0, synchronisers and debouncers cleared to 0.
REQ-030 Reset asserted mid-crossing SHALL force outputs to reset values asynchronously; pending requests are lost.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding and the secs_left width constant.
REQ-032 One sub-module, ped_debounce (synchroniser + stable counter), SHALL be instantiated once per button.
REQ-033 FSM, prescaler, countdown and request latches SHALL live in ped_panel.

Verification
REQ-034 btn_NS high 1 cycle -> ped_NS stays 0 (debounce rejects glitch).
REQ-035 btn_NS high 10 cycles, NS_green=EW_red=0 -> ped_NS=1 by cycle 2+DEBOUNCE_CYCLES+1=6 and held; wait_lamp_NS=1.
REQ-036 req_NS set, then NS_green=EW_red=1 -> walk_NS=1 for 20 cycles, dont_walk_NS flashes period 4 for 10 cycles, secs_left 6..1 then 0, ped_NS cleared at entry.
REQ-037 Both requests pending, NS_green=EW_red=1 -> NS crossing runs, req_EW stays 1; EW crossing runs later when EW_green=NS_red=1.
REQ-038 NS_green drops at cycle 8 of WALK_NS -> next cycle walk_NS=0, dont_walk_NS=1, secs_left=0, state IDLE.
REQ-039 rst asserted in FLASH_EW -> immediate reset outputs; after release no request pending.

Source files
------------

// File: rtl/ped_panel_pkg.sv
// Shared definitions for the pedestrian panel: crossing FSM encoding and
// countdown width.
package ped_panel_pkg;

    localparam int SECS_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WALK_NS,
        FLASH_NS,
        WALK_EW,
        FLASH_EW
    } state_t;

endpackage

// File: rtl/ped_debounce.sv
// Two-flop synchroniser followed by a stable-sample debouncer for one
// pedestrian button.
module ped_debounce
    import ped_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    // cnt_q counts consecutive samples that disagree with the accepted level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        db_d    = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/ped_panel.sv
// Pedestrian panel: latches debounced button requests, runs timed WALK /
// flashing DON'T-WALK crossings when the controller gives the matching green.
module ped_panel
    import ped_panel_pkg::*;
#(
    parameter int CLK_FREQ        = 5,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int WALK_SECS       = 4,
    parameter int FLASH_SECS      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_NS,
    input  logic              btn_EW,
    input  logic              NS_red,
    input  logic              NS_yellow,
    input  logic              NS_green,
    input  logic              EW_red,
    input  logic              EW_yellow,
    input  logic              EW_green,
    input  logic              ped_wait_NS,
    input  logic              ped_wait_EW,
    output logic              ped_NS,
    output logic              ped_EW,
    output logic              walk_NS,
    output logic              dont_walk_NS,
    output logic              walk_EW,
    output logic              dont_walk_EW,
    output logic              wait_lamp_NS,
    output logic              wait_lamp_EW,
    output logic [SECS_W-1:0] secs_left
);

    if (WALK_SECS + FLASH_SECS > (1 << SECS_W) - 1) begin : g_cfg_check
        $error("ped_panel: WALK_SECS + FLASH_SECS exceeds secs_left range");
    end

    localparam int PW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int HALF = (CLK_FREQ / 2 > 1) ? CLK_FREQ / 2 : 1;
    localparam int FW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [PW-1:0]     PLAST   = PW'(CLK_FREQ - 1);
    localparam logic [FW-1:0]     FLAST   = FW'(HALF - 1);
    localparam logic [SECS_W-1:0] TOTAL   = SECS_W'(WALK_SECS + FLASH_SECS);
    localparam logic [SECS_W-1:0] FLASH_L = SECS_W'(FLASH_SECS);

    logic db_ns, db_ew;
    logic rise_ns, rise_ew;
    logic green_ok;
    logic unused_yellow;

    state_t            state_q, state_d;
    logic              req_ns_q, req_ns_d, req_ew_q, req_ew_d;
    logic              prev_ns_q, prev_ns_d, prev_ew_q, prev_ew_d;
    logic [SECS_W-1:0] secs_q, secs_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              fphase_q, fphase_d;
    logic              walk_ns_q, walk_ns_d, dw_ns_q, dw_ns_d;
    logic              walk_ew_q, walk_ew_d, dw_ew_q, dw_ew_d;

    ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ns (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_NS),
        .btn_db (db_ns)
    );

    ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ew (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_EW),
        .btn_db (db_ew)
    );

    assign unused_yellow = NS_yellow ^ EW_yellow;
    assign rise_ns  = db_ns & ~prev_ns_q;
    assign rise_ew  = db_ew & ~prev_ew_q;
    assign green_ok = (state_q == WALK_NS || state_q == FLASH_NS) ? NS_green : EW_green;

    always_comb begin
        state_d   = state_q;
        req_ns_d  = req_ns_q | rise_ns;
        req_ew_d  = req_ew_q | rise_ew;
        prev_ns_d = db_ns;
        prev_ew_d = db_ew;
        secs_d    = secs_q;
        presc_d   = presc_q;
        fcnt_d    = fcnt_q;
        fphase_d  = fphase_q;

        if (state_q == IDLE) begin
            if (req_ns_q && NS_green && EW_red) begin
                state_d = WALK_NS;
                secs_d  = TOTAL;
                presc_d = '0;
            end else if (req_ew_q && EW_green && NS_red) begin
                state_d = WALK_EW;
                secs_d  = TOTAL;
                presc_d = '0;
            end
        end else if (!green_ok) begin
            state_d = IDLE;
            secs_d  = '0;
            presc_d = '0;
        end else begin
            if (presc_q == PLAST) begin
                presc_d = '0;
                if (secs_q != '0) begin
                    secs_d = secs_q - SECS_W'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end

            // secs_d is checked so the phase change lands on the same edge as the decrement.
            if (state_q == WALK_NS || state_q == WALK_EW) begin
                if (secs_d == FLASH_L) begin
                    state_d  = (state_q == WALK_NS) ? FLASH_NS : FLASH_EW;
                    fcnt_d   = '0;
                    fphase_d = 1'b1;
                end
            end else if (secs_d == '0) begin
                state_d = IDLE;
            end else if (fcnt_q == FLAST) begin
                fcnt_d   = '0;
                fphase_d = ~fphase_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // A crossing consumes its request; presses during it are dropped.
        if (state_d == WALK_NS || state_d == FLASH_NS) begin
            req_ns_d = 1'b0;
        end
        if (state_d == WALK_EW || state_d == FLASH_EW) begin
            req_ew_d = 1'b0;
        end

        walk_ns_d = (state_d == WALK_NS);
        walk_ew_d = (state_d == WALK_EW);
        dw_ns_d   = (state_d == FLASH_NS) ? fphase_d : (state_d != WALK_NS);
        dw_ew_d   = (state_d == FLASH_EW) ? fphase_d : (state_d != WALK_EW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_ns_q  <= 1'b0;
            req_ew_q  <= 1'b0;
            prev_ns_q <= 1'b0;
            prev_ew_q <= 1'b0;
            secs_q    <= '0;
            presc_q   <= '0;
            fcnt_q    <= '0;
            fphase_q  <= 1'b1;
            walk_ns_q <= 1'b0;
            dw_ns_q   <= 1'b1;
            walk_ew_q <= 1'b0;
            dw_ew_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            req_ns_q  <= req_ns_d;
            req_ew_q  <= req_ew_d;
            prev_ns_q <= prev_ns_d;
            prev_ew_q <= prev_ew_d;
            secs_q    <= secs_d;
            presc_q   <= presc_d;
            fcnt_q    <= fcnt_d;
            fphase_q  <= fphase_d;
            walk_ns_q <= walk_ns_d;
            dw_ns_q   <= dw_ns_d;
            walk_ew_q <= walk_ew_d;
            dw_ew_q   <= dw_ew_d;
        end
    end

    assign ped_NS       = req_ns_q;
    assign ped_EW       = req_ew_q;
    assign walk_NS      = walk_ns_q;
    assign dont_walk_NS = dw_ns_q;
    assign walk_EW      = walk_ew_q;
    assign dont_walk_EW = dw_ew_q;
    assign wait_lamp_NS = req_ns_q | ped_wait_NS;
    assign wait_lamp_EW = req_ew_q | ped_wait_EW;
    assign secs_left    = secs_q;

endmodule
